image_refill_scheduler: RTL and testbench
=========================================

Name: image_refill_scheduler

Overview:
Sequences host refills of the ImageController's two image buffer halves (ping-pong).
- Requests a chunk by raising irq_signal, then accepts the host's status read.
- Counts the data beats the host writes to the data window (0x30), then validates the completion write (0x40).
- Commits the filled half for display and advances the chunk index.
- Sits between the AXI slave register decode (beat/ack/status-read strobes) and the pixel-side buffer consumer (drain strobes).

Parameters:
CHUNK_BEATS, 625, 128-bit data beats per chunk (one buffer half)
CHUNK_IDX_W, 16, width of chunk index
BEAT_CNT_W, 10, width of beat counter; must satisfy 2**BEAT_CNT_W > CHUNK_BEATS

Ports:
s_axi_aclk  in  1  sole clock
s_axi_areset  in  1  synchronous, active-high reset
enable  in  1  autostart level from MasterController; low forces IDLE
num_chunks  in  CHUNK_IDX_W  chunks per frame, >=1; sampled when leaving IDLE
image_change  in  1  one-cycle pulse; abort and restart frame
status_rd  in  1  one-cycle strobe: host read status register (0x00)
beat_wr  in  1  one-cycle strobe per accepted data beat (0x30)
ack_wr  in  1  one-cycle strobe: host wrote completion register (0x40)
consume_done  in  1  one-cycle strobe: display finished a half
consume_buf  in  1  which half consume_done refers to
irq_signal  out  1  refill request, level
status_word  out  32  {15'b0, fill_buf, chunk_idx zero-extended to 16}
fill_buf  out  1  half currently being requested/filled
buf_full  out  2  per-half valid flags to consumer
err_overflow  out  1  sticky: beat_wr received with count already CHUNK_BEATS
err_short  out  1  sticky: ack_wr received with count < CHUNK_BEATS
err_spurious  out  1  sticky: beat_wr or ack_wr outside FILL

Behaviour:
- Reset values: all outputs 0; state IDLE; chunk_idx 0; beat count 0; latched num_chunks 0.
- Errors clear only on reset or on enable rising edge.
- States:
  - IDLE: irq low. On enable=1: latch num_chunks, chunk_idx=0, fill_buf=0, buf_full=0, go to SELECT.
  - SELECT: if buf_full[fill_buf]==0, go to REQ next cycle. Else if the other half is empty, toggle fill_buf and go to REQ. Else stay (both halves full).
  - REQ: irq_signal=1 from the cycle after entry. On status_rd: irq_signal=0 in the next cycle, beat count=0, go to FILL. status_word is stable throughout REQ and FILL.
  - FILL: each beat_wr increments the count, saturating at CHUNK_BEATS; a beat_wr at CHUNK_BEATS sets err_overflow and is ignored.
  - ack_wr in FILL with count==CHUNK_BEATS → COMMIT:
    - set buf_full[fill_buf];
    - chunk_idx = (chunk_idx+1 == num_chunks) ? 0 : chunk_idx+1;
    - fill_buf toggles;
    - go to SELECT.
  - ack_wr in FILL with count<CHUNK_BEATS: set err_short, discard the chunk (buffer stays empty, chunk_idx unchanged), return to REQ so the same request is re-raised.
  - COMMIT is a single cycle.
- beat_wr/ack_wr arriving in IDLE/SELECT/REQ: set err_spurious and ignore.
- status_rd outside REQ: no effect.
- consume_done clears buf_full[consume_buf] in any non-IDLE state.
  - If consume_done and COMMIT target the same half in the same cycle, the set wins.
  - Different halves: both updates apply.
- image_change (non-IDLE): synchronous abort. buf_full=0, chunk_idx=0, fill_buf=0, count=0, irq low next cycle, go to SELECT. Priority over every other strobe in that cycle.
- enable low in any state: next cycle IDLE, irq low, buf_full cleared.
- Reset mid-operation: identical to reset values, no pending strobe retained.
- Latency:
  - Drain to IRQ: consume_done of a half while blocked in SELECT → irq_signal high 2 cycles later.
  - Request to IRQ: status_rd → irq low 1 cycle later.

Decomposition:
- Shared package image_ctrl_pkg holds:
  - state enum sched_state_t {IDLE, SELECT, REQ, FILL, COMMIT};
  - register offsets IMG_STATUS_OFS=0x00, IMG_SIZE_OFS=0x20, IMG_DATA_OFS=0x30, IMG_ACK_OFS=0x40;
  - default CHUNK_BEATS.
- One natural sub-module: refill_beat_counter (saturating counter with clear, full flag and overflow pulse).
- FSM, buffer flags and chunk index stay in the top.

Test Plan:
- Start with num_chunks=3, enable=1 → irq high, status_word=0x0000_0000. status_rd plus 625 beats plus ack → buf_full=01, irq re-raised with status_word=0x0001_0001.
- Fill both halves, then irq stays low. consume_done, consume_buf=0 → irq high 2 cycles later, status_word=0x0000_0002. Next commit wraps chunk_idx to 0.
- Ack after 624 beats → err_short=1, buf_full unchanged, irq re-raised with the same status_word. A 626th beat in a full fill → err_overflow=1 and the count stays 625.
- image_change during FILL at beat 300 → buf_full=00, chunk_idx=0, fill_buf=0, irq high again. Later beats are counted from 0 only after a new status_rd.
- COMMIT of half 1 in the same cycle as consume_done on half 1 → buf_full[1]=1. A beat_wr in REQ → err_spurious=1.
- s_axi_areset asserted mid-FILL → all outputs 0 next cycle; enable still high → re-request chunk 0 after reset releases.

Source files
------------

// File: rtl/image_ctrl_pkg.sv
// Shared types and constants for the ImageController refill path.
// Register offsets mirror the AXI slave decode.
package image_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        FILL,
        COMMIT
    } sched_state_t;

    localparam logic [7:0] IMG_STATUS_OFS = 8'h00;
    localparam logic [7:0] IMG_SIZE_OFS   = 8'h20;
    localparam logic [7:0] IMG_DATA_OFS   = 8'h30;
    localparam logic [7:0] IMG_ACK_OFS    = 8'h40;

    localparam int DEF_CHUNK_BEATS = 625;

endpackage

// File: rtl/refill_beat_counter.sv
// Saturating beat counter for one chunk fill.
// Reports full and flags a beat that arrives once already full.
module refill_beat_counter #(
    parameter int MAX_BEATS = 625,
    parameter int CNT_W     = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_full,
    output logic o_ovf
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_BEATS);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_full) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_full = (r_count == LIM);
    assign o_ovf  = i_inc && o_full;

endmodule

// File: rtl/image_refill_scheduler.sv
// Ping-pong refill sequencer: raises refill requests to the host,
// counts data beats, validates completion and publishes filled halves.
module image_refill_scheduler
    import image_ctrl_pkg::*;
#(
    parameter int CHUNK_BEATS = DEF_CHUNK_BEATS,
    parameter int CHUNK_IDX_W = 16,
    parameter int BEAT_CNT_W  = 10
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_areset,
    input  logic                   enable,
    input  logic [CHUNK_IDX_W-1:0] num_chunks,
    input  logic                   image_change,
    input  logic                   status_rd,
    input  logic                   beat_wr,
    input  logic                   ack_wr,
    input  logic                   consume_done,
    input  logic                   consume_buf,
    output logic                   irq_signal,
    output logic [31:0]            status_word,
    output logic                   fill_buf,
    output logic [1:0]             buf_full,
    output logic                   err_overflow,
    output logic                   err_short,
    output logic                   err_spurious
);

    sched_state_t           r_state;
    sched_state_t           w_next;
    logic                   r_irq;
    logic                   r_fill_buf;
    logic [1:0]             r_buf_full;
    logic [CHUNK_IDX_W-1:0] r_chunk_idx;
    logic [CHUNK_IDX_W-1:0] r_num_chunks;
    logic                   r_en_d;
    logic                   r_err_ovf;
    logic                   r_err_short;
    logic                   r_err_spur;

    logic                   w_abort;
    logic                   w_in_fill;
    logic                   w_start;
    logic                   w_inc;
    logic                   w_cnt_full;
    logic                   w_ovf;
    logic                   w_commit;
    logic                   w_sel_toggle;
    logic [1:0]             w_full_next;
    logic [CHUNK_IDX_W-1:0] w_idx_inc;
    logic [CHUNK_IDX_W-1:0] w_idx_next;

    // A frame restart beats every other strobe in the same cycle
    assign w_abort    = enable && image_change && (r_state != IDLE);
    assign w_in_fill  = (r_state == FILL);
    assign w_start    = (r_state == REQ) && status_rd;
    assign w_inc      = beat_wr && w_in_fill && !w_abort;
    assign w_commit   = (r_state == COMMIT);
    assign w_idx_inc  = r_chunk_idx + 1'b1;
    assign w_idx_next = (w_idx_inc == r_num_chunks) ? '0 : w_idx_inc;

    refill_beat_counter #(
        .MAX_BEATS(CHUNK_BEATS),
        .CNT_W    (BEAT_CNT_W)
    ) u_cnt (
        .i_clk (s_axi_aclk),
        .i_rst (s_axi_areset),
        .i_clr (w_abort || w_start),
        .i_inc (w_inc),
        .o_full(w_cnt_full),
        .o_ovf (w_ovf)
    );

    always_comb begin
        w_next       = r_state;
        w_sel_toggle = 1'b0;
        if (!enable) begin
            w_next = IDLE;
        end else if (w_abort) begin
            w_next = SELECT;
        end else begin
            unique case (r_state)
                IDLE:   w_next = SELECT;
                SELECT: begin
                    if (!r_buf_full[r_fill_buf]) begin
                        w_next = REQ;
                    end else if (!r_buf_full[~r_fill_buf]) begin
                        w_next       = REQ;
                        w_sel_toggle = 1'b1;
                    end
                end
                REQ:    if (status_rd) w_next = FILL;
                FILL:   if (ack_wr) w_next = w_cnt_full ? COMMIT : REQ;
                COMMIT: w_next = SELECT;
                default: w_next = IDLE;
            endcase
        end
    end

    // Commit is applied after the drain clear so a same-half set wins
    always_comb begin
        w_full_next = r_buf_full;
        if (consume_done) w_full_next[consume_buf] = 1'b0;
        if (w_commit)     w_full_next[r_fill_buf]  = 1'b1;
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state      <= IDLE;
            r_irq        <= 1'b0;
            r_fill_buf   <= 1'b0;
            r_buf_full   <= '0;
            r_chunk_idx  <= '0;
            r_num_chunks <= '0;
            r_en_d       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en_d  <= enable;
            r_irq   <= (r_state == REQ) && (w_next == REQ);
            if (!enable) begin
                r_buf_full <= '0;
            end else if (r_state == IDLE) begin
                r_buf_full   <= '0;
                r_fill_buf   <= 1'b0;
                r_chunk_idx  <= '0;
                r_num_chunks <= num_chunks;
            end else if (w_abort) begin
                r_buf_full  <= '0;
                r_fill_buf  <= 1'b0;
                r_chunk_idx <= '0;
            end else begin
                r_buf_full <= w_full_next;
                if (w_sel_toggle || w_commit) r_fill_buf <= ~r_fill_buf;
                if (w_commit) r_chunk_idx <= w_idx_next;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset || (enable && !r_en_d)) begin
            r_err_ovf   <= 1'b0;
            r_err_short <= 1'b0;
            r_err_spur  <= 1'b0;
        end else if (!w_abort) begin
            if (w_ovf) r_err_ovf <= 1'b1;
            if (ack_wr && w_in_fill && !w_cnt_full) r_err_short <= 1'b1;
            if ((beat_wr || ack_wr) && !w_in_fill) r_err_spur <= 1'b1;
        end
    end

    assign irq_signal   = r_irq;
    assign fill_buf     = r_fill_buf;
    assign buf_full     = r_buf_full;
    assign status_word  = {15'b0, r_fill_buf, 16'(r_chunk_idx)};
    assign err_overflow = r_err_ovf;
    assign err_short    = r_err_short;
    assign err_spurious = r_err_spur;

endmodule

// File: tb/tb_image_refill_scheduler.sv
// Directed bench for image_refill_scheduler with a cycle-level
// reference of the refill protocol and literal spot checks.
module tb_image_refill_scheduler;

    localparam int CB = 625;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] num = 16'd0;
    logic        image_change = 1'b0;
    logic        status_rd = 1'b0;
    logic        beat_wr = 1'b0;
    logic        ack_wr = 1'b0;
    logic        consume_done = 1'b0;
    logic        consume_buf = 1'b0;
    logic        irq;
    logic [31:0] status;
    logic        fb;
    logic [1:0]  full;
    logic        e_ovf, e_short, e_spur;

    int n_total = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    image_refill_scheduler dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .enable      (en),
        .num_chunks  (num),
        .image_change(image_change),
        .status_rd   (status_rd),
        .beat_wr     (beat_wr),
        .ack_wr      (ack_wr),
        .consume_done(consume_done),
        .consume_buf (consume_buf),
        .irq_signal  (irq),
        .status_word (status),
        .fill_buf    (fb),
        .buf_full    (full),
        .err_overflow(e_ovf),
        .err_short   (e_short),
        .err_spurious(e_spur)
    );

    always #5 clk = ~clk;

    // Reference: protocol phases of one refill conversation
    localparam int P_OFF  = 0;
    localparam int P_WAIT = 1;
    localparam int P_ASK  = 2;
    localparam int P_RECV = 3;
    localparam int P_PUB  = 4;

    int       m_ph = P_OFF;
    int       m_age = 0;
    int       m_idx = 0;
    int       m_nc = 0;
    int       m_cnt = 0;
    bit       m_fb = 0;
    bit [1:0] m_full = 0;
    bit       m_ovf = 0, m_short = 0, m_spur = 0, m_en_d = 0;

    always @(posedge clk) begin
        bit       ab;
        bit [1:0] old;
        if (rst) begin
            m_ph = P_OFF; m_age = 0; m_idx = 0; m_nc = 0; m_cnt = 0;
            m_fb = 0; m_full = 0; m_ovf = 0; m_short = 0; m_spur = 0;
            m_en_d = 0;
        end else begin
            ab  = en && image_change && m_ph != P_OFF;
            old = m_full;
            if (en && !m_en_d) begin
                m_ovf = 0; m_short = 0; m_spur = 0;
            end else if (!ab) begin
                if (m_ph == P_RECV) begin
                    if (beat_wr && m_cnt == CB) m_ovf = 1;
                    if (ack_wr && m_cnt != CB) m_short = 1;
                end else if (beat_wr || ack_wr) begin
                    m_spur = 1;
                end
            end
            m_en_d = en;
            if (!en) begin
                m_ph = P_OFF; m_full = 0;
            end else if (m_ph == P_OFF) begin
                m_nc = num; m_idx = 0; m_fb = 0; m_full = 0; m_ph = P_WAIT;
            end else if (ab) begin
                m_full = 0; m_idx = 0; m_fb = 0; m_cnt = 0; m_ph = P_WAIT;
            end else begin
                if (consume_done) m_full[consume_buf] = 0;
                case (m_ph)
                    P_WAIT: begin
                        if (!old[m_fb]) begin
                            m_ph = P_ASK; m_age = 0;
                        end else if (!old[!m_fb]) begin
                            m_fb = !m_fb; m_ph = P_ASK; m_age = 0;
                        end
                    end
                    P_ASK: begin
                        if (status_rd) begin
                            m_cnt = 0; m_ph = P_RECV;
                        end else begin
                            m_age++;
                        end
                    end
                    P_RECV: begin
                        if (ack_wr) begin
                            if (m_cnt == CB) m_ph = P_PUB;
                            else begin m_ph = P_ASK; m_age = 0; end
                        end
                        if (beat_wr && m_cnt < CB) m_cnt++;
                    end
                    default: begin
                        m_full[m_fb] = 1;
                        m_idx = (m_idx + 1 == m_nc) ? 0 : m_idx + 1;
                        m_fb = !m_fb;
                        m_ph = P_WAIT;
                    end
                endcase
            end
        end
    end

    function automatic logic [38:0] exp_vec();
        logic [31:0] sw;
        logic        ei;
        sw = {15'b0, m_fb, 16'(m_idx)};
        ei = (m_ph == P_ASK) && (m_age >= 1);
        return {ei, sw, m_fb, m_full, m_ovf, m_short, m_spur};
    endfunction

    always @(negedge clk) begin
        logic [38:0] a, e;
        if (chk_on) begin
            a = {irq, status, fb, full, e_ovf, e_short, e_spur};
            e = exp_vec();
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL cycle t=%0t act=%h exp=%h", $time, a, e);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%h exp=%h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_irq(input string nm);
        int k;
        k = 0;
        while (irq !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(nm, {31'b0, irq}, 32'd1);
    endtask

    task automatic fill(input int beats, input bit do_ack);
        status_rd = 1; tick(1); status_rd = 0;
        beat_wr = 1; tick(beats); beat_wr = 0;
        if (do_ack) begin
            ack_wr = 1; tick(1); ack_wr = 0;
        end
    endtask

    task automatic drain(input bit b);
        consume_done = 1; consume_buf = b; tick(1);
        consume_done = 0; consume_buf = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        tick(3);
        chk_on = 1;
        chk("reset_irq", {31'b0, irq}, 32'd0);
        chk("reset_status", status, 32'h0);
        rst = 0; en = 1; num = 16'd3;
        wait_irq("irq_first");
        chk("status_first", status, 32'h0000_0000);

        fill(CB, 1);
        wait_irq("irq_second");
        chk("status_second", status, 32'h0001_0001);
        chk("full_one", {30'b0, full}, 32'd1);

        fill(CB, 1);
        tick(10);
        chk("blocked_irq", {31'b0, irq}, 32'd0);
        chk("blocked_full", {30'b0, full}, 32'd3);

        drain(0);
        chk("drain_lat0", {31'b0, irq}, 32'd0);
        tick(1);
        chk("drain_lat1", {31'b0, irq}, 32'd0);
        tick(1);
        chk("drain_lat2", {31'b0, irq}, 32'd1);
        chk("status_third", status, 32'h0000_0002);

        fill(CB, 1);
        tick(4);
        chk("wrap_status", status, 32'h0001_0000);

        drain(1);
        wait_irq("irq_half1");
        fill(CB - 1, 1);
        wait_irq("irq_reraise");
        chk("short_err", {31'b0, e_short}, 32'd1);
        chk("short_full", {30'b0, full}, 32'd1);
        chk("short_status", status, 32'h0001_0000);

        fill(CB + 1, 1);
        tick(3);
        chk("ovf_err", {31'b0, e_ovf}, 32'd1);
        chk("ovf_commit", {30'b0, full}, 32'd3);
        chk("ovf_status", status, 32'h0000_0001);

        drain(0);
        wait_irq("irq_pre_abort");
        fill(300, 0);
        image_change = 1; tick(1); image_change = 0;
        chk("abort_full", {30'b0, full}, 32'd0);
        chk("abort_status", status, 32'h0);
        wait_irq("irq_post_abort");
        fill(CB, 1);
        wait_irq("irq_after_abort_fill");
        chk("abort_refill", status, 32'h0001_0001);

        fill(CB, 0);
        ack_wr = 1; tick(1); ack_wr = 0;
        drain(1);
        chk("set_wins", {30'b0, full}, 32'd3);

        drain(0);
        wait_irq("irq_spur");
        beat_wr = 1; tick(1); beat_wr = 0;
        chk("spur_err", {31'b0, e_spur}, 32'd1);

        fill(100, 0);
        rst = 1; tick(1);
        chk("rst_mid", {irq, status[30:0]}, 32'h0);
        chk("rst_flags", {27'b0, fb, full, e_ovf, e_short}, 32'h0);
        rst = 0;
        wait_irq("irq_after_rst");
        chk("rst_status", status, 32'h0);

        beat_wr = 1; tick(1); beat_wr = 0;
        en = 0; tick(2);
        chk("dis_irq", {30'b0, irq, full[0]}, 32'd0);
        en = 1; tick(1);
        chk("en_clear", {31'b0, e_spur}, 32'd0);
        wait_irq("irq_reenable");

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
